// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring shift-subtract divider for DIV / DIVU.
// Produces quotient (LO) and remainder (HI) one quotient bit per cycle behind
// a start/busy/done handshake. Optional build macro DIV_EARLY_ZERO_EN sends a
// divide-by-zero straight to the fix-up state so it completes in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } stateT;

  stateT state, nextState;

  // Working registers: {rem, quo} shift pair and per-operation context.
  logic [2*WIDTH-1:0] remQuo;
  logic [CntW-1:0]    iterCnt;
  logic [WIDTH-1:0]   magDivisor;
  logic [WIDTH-1:0]   capDividend;
  logic               negQuo;
  logic               negRem;
  logic               zeroDiv;

  // Combinational helpers.
  logic [WIDTH-1:0]   absDividend;
  logic [WIDTH-1:0]   absDivisor;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] stepRemQuo;
  logic [WIDTH-1:0]   quoMag;
  logic [WIDTH-1:0]   remMag;
  logic [WIDTH-1:0]   fixQuo;
  logic [WIDTH-1:0]   fixRem;

  assign busy = (state != IDLE);

  // Operand magnitudes at capture; the most negative value maps to 2^(W-1),
  // which still fits because the magnitude is held unsigned.
  always_comb begin
    absDividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    absDivisor  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // One restoring iteration: shift left, trial-subtract at W+1 bits, keep or restore.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted    = {remQuo, 1'b0};
    trial      = shifted[2*WIDTH:WIDTH] - {1'b0, magDivisor};
    stepRemQuo = shifted[2*WIDTH-1:0];
    if (!trial[WIDTH]) begin
      stepRemQuo = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

  // Sign fix-up and divide-by-zero override applied in the FIX state.
  always_comb begin
    quoMag = remQuo[WIDTH-1:0];
    remMag = remQuo[2*WIDTH-1:WIDTH];
    fixQuo = negQuo ? -quoMag : quoMag;
    fixRem = negRem ? -remMag : remMag;
    if (zeroDiv) begin
      fixQuo = '1;
      fixRem = capDividend;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_EARLY_ZERO_EN
          nextState = (divisor == '0) ? FIX : RUN;
`else
          nextState = RUN;
`endif
        end
      end
      RUN:     if (iterCnt == LastIter) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, iterate in RUN, publish results in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remQuo      <= '0;
      iterCnt     <= '0;
      magDivisor  <= '0;
      capDividend <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      zeroDiv     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            remQuo      <= {{WIDTH{1'b0}}, absDividend};
            iterCnt     <= '0;
            magDivisor  <= absDivisor;
            capDividend <= dividend;
            negQuo      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negRem      <= is_signed & dividend[WIDTH-1];
            zeroDiv     <= (divisor == '0);
          end
        end
        RUN: begin
          remQuo  <= stepRemQuo;
          iterCnt <= iterCnt + 1'b1;
        end
        FIX: begin
          quotient    <= fixQuo;
          remainder   <= fixRem;
          div_by_zero <= zeroDiv;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an
// arithmetic reference model (64-bit integer division on sign/zero-extended
// operands). Honours DIV_EARLY_ZERO_EN for the expected divide-by-zero latency.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int nChecks = 0;
  int nFails = 0;

  // Last published results expected from the model; outputs must hold these until the next done.
  logic [31:0] prevQ = '0;
  logic [31:0] prevR = '0;
  logic        prevZ = 1'b0;

`ifdef DIV_EARLY_ZERO_EN
  localparam bit EarlyZero = 1'b1;
`else
  localparam bit EarlyZero = 1'b0;
`endif

  div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: {quotient, remainder, div_by_zero} from plain integer arithmetic.
  function automatic logic [64:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return {32'hFFFF_FFFF, a, 1'b1};
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
    end else begin
      sa = $signed({32'h0, a});
      sb = $signed({32'h0, b});
    end
    q = 32'(sa / sb);
    r = 32'(sa % sb);
    return {q, r, 1'b0};
  endfunction

  function automatic int expLat(input logic [31:0] b);
    return (EarlyZero && b == 32'h0) ? 1 : 33;
  endfunction

  // Present one start for a single edge; returns #1 after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; reports cycles since the last edge, busy cycles, result hold and results.
  task automatic waitDone(output int lat, output int busyCnt, output bit held,
                          output bit busyAtDone, output logic [64:0] res);
    lat        = -1;
    busyCnt    = busy ? 1 : 0;
    held       = 1'b1;
    busyAtDone = 1'b1;
    res        = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat        = k;
        busyAtDone = busy;
        res        = {quotient, remainder, div_by_zero};
        break;
      end
      if (busy) busyCnt++;
      if ({quotient, remainder, div_by_zero} !== {prevQ, prevR, prevZ}) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'h0) begin
      nFails++;
      $display("FAIL reset_state got busy=%b done=%b q=%h r=%h z=%b want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [64:0] literal);
    int lat, busyCnt;
    bit held, bad;
    logic [64:0] res, expRes;
    expRes = refDiv(a, b, s);
    launch(a, b, s);
    waitDone(lat, busyCnt, held, bad, res);
    nChecks++;
    if (res !== expRes || res !== literal) begin
      nFails++;
      $display("FAIL %s results got q=%h r=%h z=%b want q=%h r=%h z=%b", name,
               res[64:33], res[32:1], res[0], literal[64:33], literal[32:1], literal[0]);
    end
    nChecks++;
    if (lat !== expLat(b) || busyCnt !== expLat(b) || !held || bad) begin
      nFails++;
      $display("FAIL %s timing got lat=%0d busy=%0d held=%b busyAtDone=%b want lat=%0d busy=%0d held=1 busyAtDone=0",
               name, lat, busyCnt, held, bad, expLat(b), expLat(b));
    end
    {prevQ, prevR, prevZ} = expRes;
  endtask

  task automatic test_ignored_start();
    int lat, busyCnt;
    bit held, bad;
    logic [64:0] res, expRes;
    expRes = refDiv(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    launch(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    launch(32'h0000_0005, 32'h0000_0001, 1'b1);
    waitDone(lat, busyCnt, held, bad, res);
    nChecks++;
    if (res !== expRes) begin
      nFails++;
      $display("FAIL ignored_start results got q=%h r=%h z=%b want q=%h r=%h z=%b",
               res[64:33], res[32:1], res[0], expRes[64:33], expRes[32:1], expRes[0]);
    end
    nChecks++;
    if (lat !== 28 || !held) begin
      nFails++;
      $display("FAIL ignored_start timing got lat=%0d held=%b want lat=28 held=1", lat, held);
    end
    {prevQ, prevR, prevZ} = expRes;
  endtask

  task automatic test_back_to_back();
    int lat, busyCnt;
    bit held, bad;
    logic [64:0] res, expA, expB;
    expA = refDiv(32'd123_456_789, 32'd1000, 1'b0);
    expB = refDiv(32'hFFFF_0000, 32'd3, 1'b0);
    launch(32'd123_456_789, 32'd1000, 1'b0);
    waitDone(lat, busyCnt, held, bad, res);
    {prevQ, prevR, prevZ} = expA;
    launch(32'hFFFF_0000, 32'd3, 1'b0);
    nChecks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nFails++;
      $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    nChecks++;
    if (res !== expA) begin
      nFails++;
      $display("FAIL b2b_first got q=%h r=%h want q=%h r=%h", res[64:33], res[32:1], expA[64:33], expA[32:1]);
    end
    waitDone(lat, busyCnt, held, bad, res);
    nChecks++;
    if (res !== expB || lat !== 33 || !held) begin
      nFails++;
      $display("FAIL b2b_second got q=%h r=%h lat=%0d held=%b want q=%h r=%h lat=33 held=1",
               res[64:33], res[32:1], lat, held, expB[64:33], expB[32:1]);
    end
    {prevQ, prevR, prevZ} = expB;
  endtask

  task automatic test_reset_mid_op();
    launch(32'h7000_0000, 32'd9, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'h0) begin
      nFails++;
      $display("FAIL reset_mid_op got busy=%b done=%b q=%h r=%h z=%b want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    {prevQ, prevR, prevZ} = 65'h0;
    test_directed("after_reset", 32'd1000, 32'd10, 1'b0, {32'd100, 32'd0, 1'b0});
  endtask

  task automatic test_random(input int n);
    int lat, busyCnt;
    bit held, bad;
    logic [31:0] a, b;
    logic s;
    logic [64:0] res, expRes;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h1;
        3:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      expRes = refDiv(a, b, s);
      launch(a, b, s);
      waitDone(lat, busyCnt, held, bad, res);
      nChecks++;
      if (res !== expRes || lat !== expLat(b) || busyCnt !== expLat(b) || !held || bad) begin
        nFails++;
        $display("FAIL random[%0d] a=%h b=%h s=%b got q=%h r=%h z=%b lat=%0d busy=%0d held=%b want q=%h r=%h z=%b lat=%0d",
                 i, a, b, s, res[64:33], res[32:1], res[0], lat, busyCnt, held,
                 expRes[64:33], expRes[32:1], expRes[0], expLat(b));
      end
      {prevQ, prevR, prevZ} = expRes;
    end
  endtask

  initial begin
    test_reset();
    test_directed("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'd14, 32'd2, 1'b0});
    test_directed("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    test_directed("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFD, 32'd1, 1'b0});
    test_directed("sdiv_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'd3, 32'hFFFF_FFFF, 1'b0});
    test_directed("udiv_big_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'h7FFF_FFFC, 32'd1, 1'b0});
    test_directed("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'd0, 1'b0});
    test_directed("udiv_by_zero", 32'h1234_5678, 32'h0, 1'b0, {32'hFFFF_FFFF, 32'h1234_5678, 1'b1});
    test_directed("sdiv_by_zero", 32'h1234_5678, 32'h0, 1'b1, {32'hFFFF_FFFF, 32'h1234_5678, 1'b1});
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
